gpio_irq_sequencer: RTL

GPIO_IRQ_SEQUENCER -- requirements
Module: gpio_irq_sequencer

---
 rtl/gpio_irq_sequencer.sv | 96 +++++++++
 1 files changed

// File: rtl/gpio_irq_sequencer.sv
// gpio_irq_sequencer: services an edge-capture PIO interrupt and queues {edges, port snapshot} events in a FIFO
module gpio_irq_sequencer #(
  parameter logic [31:0] INIT_MASK  = 32'hFFFF_FFFF,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          irq_in,
  output logic [1:0]                    m_address,
  output logic                          m_chipselect,
  output logic                          m_write_n,
  output logic [31:0]                   m_writedata,
  input  logic [31:0]                   m_readdata,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [31:0]                   ev_edges,
  output logic [31:0]                   ev_data,
  output logic [$clog2(FIFO_DEPTH):0]   ev_count,
  output logic                          busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [2:0] {INIT, IDLE, RD_EDGE, WAIT_EDGE, RD_DATA, WAIT_DATA, CLR, PUSH} state_t;
  state_t state;
  logic [31:0] edge_reg, data_reg;
  logic [63:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push, pop;
  assign push = state == PUSH;
  assign pop = ev_valid && ev_ready;
  assign ev_valid = |ev_count;
  assign ev_edges = mem[rd_ptr][63:32];
  assign ev_data = mem[rd_ptr][31:0];
  assign busy = state != IDLE;
  // Bus outputs are registered on entry to a state, so each access is presented for exactly the cycle that state is held.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= INIT;
      m_chipselect <= 1'b0;
      m_write_n <= 1'b1;
      m_address <= 2'd0;
      m_writedata <= 32'd0;
      edge_reg <= 32'd0;
      data_reg <= 32'd0;
    end else begin
      m_chipselect <= 1'b0;
      m_write_n <= 1'b1;
      m_address <= 2'd0;
      m_writedata <= 32'd0;
      case (state)
        INIT: begin
          state <= IDLE;
          m_chipselect <= 1'b1;
          m_write_n <= 1'b0;
          m_address <= 2'd2;
          m_writedata <= INIT_MASK;
        end
        IDLE: if (irq_in && !ev_count[AW]) begin
          state <= RD_EDGE;
          m_chipselect <= 1'b1;
          m_address <= 2'd3;
        end
        RD_EDGE: state <= WAIT_EDGE;
        WAIT_EDGE: begin
          edge_reg <= m_readdata;
          state <= RD_DATA;
          m_chipselect <= 1'b1;
        end
        RD_DATA: state <= WAIT_DATA;
        WAIT_DATA: begin
          data_reg <= m_readdata;
          state <= (edge_reg == 32'd0) ? IDLE : CLR;
          m_chipselect <= edge_reg != 32'd0;
          m_write_n <= edge_reg == 32'd0;
          m_address <= (edge_reg == 32'd0) ? 2'd0 : 2'd3;
          m_writedata <= edge_reg;
        end
        CLR: state <= PUSH;
        PUSH: state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ev_count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      ev_count <= ev_count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {edge_reg, data_reg};
endmodule
